// File: rtl/i4001_rom_if.sv
// MCS-4 CPU bus as seen by a 4001: phase clock, sync, ROM command and
// the 4-bit data bus split into pad input and chip drive.
interface i4001_rom_if;
    logic       clk2;
    logic       sync;
    logic       cmrom;
    logic [3:0] data_in;
    logic [3:0] data_out;
    logic       data_oe;
    logic       fetch_sel;

    // CPU side (and bus pads): drives timing and bus value, sees chip drive
    modport master (
        output clk2, sync, cmrom, data_in,
        input  data_out, data_oe, fetch_sel
    );

    // ROM chip side
    modport slave (
        input  clk2, sync, cmrom, data_in,
        output data_out, data_oe, fetch_sel
    );
endinterface

// File: rtl/i4001_rom.sv
// 4001 ROM / I/O-port responder. Follows the 8-subcycle instruction cycle,
// latches the program address, returns the opcode as OPR then OPA, and
// services SRC/WRR/RDR for its own 4-bit port. ROM contents are external.
module i4001_rom #(
    parameter logic [3:0] CHIP_ID      = 4'h0,
    parameter logic [3:0] IO_OUT_RESET = 4'h0
) (
    input  logic         sysclk,
    input  logic         poc_n,
    i4001_rom_if.slave   bus,
    output logic [7:0]   rom_addr,
    input  logic [7:0]   rom_data,
    input  logic [3:0]   io_in,
    output logic [3:0]   io_out
);

    typedef enum logic [3:0] {
        UNSYNC, A1, A2, A3, M1, M2, X1, X2, X3
    } phase_t;

    localparam logic [3:0] OPA_WRR = 4'b0010;
    localparam logic [3:0] OPA_RDR = 4'b1010;

    phase_t     phase;
    logic       clk2_q;
    logic       sel;
    logic       io_pending;
    logic       src_match;
    logic [3:0] word_lo;
    logic [3:0] opa;
    logic [3:0] out_q;
    logic       oe_q;
    logic       fsel_q;
    logic       tick;
    logic       chip_hit;
    logic       io_hit;

    assign tick     = clk2_q & ~bus.clk2;
    assign chip_hit = (bus.data_in == CHIP_ID) & bus.cmrom;
    assign io_hit   = io_pending & src_match;

    assign bus.data_out  = out_q;
    assign bus.data_oe   = oe_q;
    assign bus.fetch_sel = fsel_q;

    // Phase tracking, address/opcode handling and I/O port, all on subcycle ticks.
    // OPR is loaded straight from rom_data at the A3 tick so it is on the bus
    // for all of M1; only the OPA nibble needs to be held for M2.
    always_ff @(posedge sysclk) begin
        if (!poc_n) begin
            phase      <= UNSYNC;
            clk2_q     <= 1'b0;
            sel        <= 1'b0;
            io_pending <= 1'b0;
            src_match  <= 1'b0;
            word_lo    <= '0;
            opa        <= '0;
            out_q      <= '0;
            oe_q       <= 1'b0;
            fsel_q     <= 1'b0;
            rom_addr   <= '0;
            io_out     <= IO_OUT_RESET;
        end else begin
            clk2_q <= bus.clk2;
            if (tick) begin
                if (bus.sync) begin
                    phase      <= A1;
                    sel        <= 1'b0;
                    io_pending <= 1'b0;
                    oe_q       <= 1'b0;
                    fsel_q     <= 1'b0;
                end else begin
                    case (phase)
                        A1: begin
                            rom_addr[3:0] <= bus.data_in;
                            phase         <= A2;
                        end
                        A2: begin
                            rom_addr[7:4] <= bus.data_in;
                            phase         <= A3;
                        end
                        A3: begin
                            sel     <= chip_hit;
                            word_lo <= rom_data[3:0];
                            out_q   <= rom_data[7:4];
                            oe_q    <= chip_hit;
                            fsel_q  <= chip_hit;
                            phase   <= M1;
                        end
                        M1: begin
                            if (sel) out_q <= word_lo;
                            phase <= M2;
                        end
                        M2: begin
                            oe_q   <= 1'b0;
                            fsel_q <= 1'b0;
                            if (bus.cmrom) begin
                                io_pending <= 1'b1;
                                opa        <= bus.data_in;
                            end
                            phase <= X1;
                        end
                        X1: begin
                            if (io_hit && opa == OPA_RDR) begin
                                oe_q  <= 1'b1;
                                out_q <= io_in;
                            end
                            phase <= X2;
                        end
                        X2: begin
                            oe_q <= 1'b0;
                            if (bus.cmrom) src_match <= (bus.data_in == CHIP_ID);
                            if (io_hit && opa == OPA_WRR) io_out <= bus.data_in;
                            phase <= X3;
                        end
                        X3: begin
                            sel        <= 1'b0;
                            io_pending <= 1'b0;
                            oe_q       <= 1'b0;
                            fsel_q     <= 1'b0;
                            phase      <= UNSYNC;
                        end
                        default: phase <= UNSYNC;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i4001_rom.sv
// Directed bench for i4001_rom: table of per-subcycle bus values with
// expected chip outputs after each tick, plus hand sequences for resync,
// loss of sync and reset during a fetch drive.
module tb_i4001_rom;

    logic       sysclk = 1'b0;
    logic       poc_n;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [3:0] io_in;
    logic [3:0] io_out;

    i4001_rom_if bus();

    i4001_rom #(.CHIP_ID(4'h3), .IO_OUT_RESET(4'hC)) dut (
        .sysclk   (sysclk),
        .poc_n    (poc_n),
        .bus      (bus),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .io_in    (io_in),
        .io_out   (io_out)
    );

    always #5 sysclk = ~sysclk;

    // external ROM image: one programmed word
    assign rom_data = (rom_addr == 8'hA5) ? 8'hD7 : 8'h00;

    typedef struct {
        logic [3:0] din;
        logic       cm;
        logic       sy;
        logic       oe;
        logic [3:0] dout;
        logic       fs;
        logic [3:0] io;
        logic       ra_chk;
        logic [7:0] ra;
    } vec_t;

    vec_t tbl [80];
    int   nvec = 0;
    int   checks = 0;
    int   errors = 0;
    logic oe_seen = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] d, input logic c, input logic s, input logic oe,
                       input logic [3:0] dout, input logic fs, input logic [3:0] io,
                       input logic ra_chk, input logic [7:0] ra);
        tbl[nvec] = '{d, c, s, oe, dout, fs, io, ra_chk, ra};
        nvec++;
    endtask

    // one full instruction cycle A1..X3 (X3 carries sync)
    task automatic cyc(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3, input logic cm3,
                       input logic [3:0] m1, input logic [3:0] m2, input logic cmm2,
                       input logic [3:0] x2, input logic cmx2,
                       input logic fetch, input logic [3:0] hi, input logic [3:0] lo,
                       input logic rdr, input logic [3:0] io_b, input logic [3:0] io_a);
        add(a1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, io_b, 1'b0, 8'h00);
        add(a2, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, io_b, 1'b1, {a2, a1});
        add(a3, cm3, 1'b0, fetch, hi, fetch, io_b, 1'b0, 8'h00);
        add(m1, 1'b0, 1'b0, fetch, lo, fetch, io_b, 1'b0, 8'h00);
        add(m2, cmm2, 1'b0, 1'b0, 4'h0, 1'b0, io_b, 1'b0, 8'h00);
        add(4'h0, 1'b0, 1'b0, rdr, 4'h6, 1'b0, io_b, 1'b0, 8'h00);
        add(x2, cmx2, 1'b0, 1'b0, 4'h0, 1'b0, io_a, 1'b0, 8'h00);
        add(4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, io_a, 1'b0, 8'h00);
    endtask

    // one subcycle: clk2 high for two sysclks, then falls; returns on the
    // negedge after the tick so registered results are visible
    task automatic sub(input logic [3:0] d, input logic c, input logic s);
        bus.data_in = d;
        bus.cmrom   = c;
        bus.sync    = s;
        bus.clk2    = 1'b1;
        repeat (2) begin
            @(negedge sysclk);
            oe_seen = oe_seen | bus.data_oe;
        end
        bus.clk2 = 1'b0;
        @(negedge sysclk);
        oe_seen = oe_seen | bus.data_oe;
    endtask

    initial begin
        poc_n       = 1'b0;
        bus.clk2    = 1'b0;
        bus.sync    = 1'b0;
        bus.cmrom   = 1'b0;
        bus.data_in = 4'h0;
        io_in       = 4'h6;

        // stimulus table
        add(4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'hC, 1'b0, 8'h00);
        cyc(4'h5, 4'hA, 4'h3, 1'b1, 4'hD, 4'h7, 1'b0, 4'h0, 1'b0, 1'b1, 4'hD, 4'h7, 1'b0, 4'hC, 4'hC);
        cyc(4'h5, 4'hA, 4'h2, 1'b1, 4'hD, 4'h7, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'hC, 4'hC);
        cyc(4'h0, 4'h0, 4'h0, 1'b0, 4'h2, 4'h1, 1'b0, 4'h3, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'hC, 4'hC);
        cyc(4'h0, 4'h0, 4'h0, 1'b0, 4'hE, 4'h2, 1'b1, 4'h9, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'hC, 4'h9);
        cyc(4'h0, 4'h0, 4'h0, 1'b0, 4'h2, 4'h1, 1'b0, 4'h4, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h9, 4'h9);
        cyc(4'h0, 4'h0, 4'h0, 1'b0, 4'hE, 4'h2, 1'b1, 4'h5, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h9, 4'h9);
        cyc(4'h0, 4'h0, 4'h0, 1'b0, 4'h2, 4'h1, 1'b0, 4'h3, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h9, 4'h9);
        cyc(4'h0, 4'h0, 4'h0, 1'b0, 4'hE, 4'hA, 1'b1, 4'h6, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h9, 4'h9);

        // reset state
        repeat (3) @(negedge sysclk);
        chk("rst_oe", {7'd0, bus.data_oe}, 8'h00);
        chk("rst_dout", {4'd0, bus.data_out}, 8'h00);
        chk("rst_fsel", {7'd0, bus.fetch_sel}, 8'h00);
        chk("rst_addr", rom_addr, 8'h00);
        chk("rst_io", {4'd0, io_out}, 8'h0C);
        poc_n = 1'b1;
        @(negedge sysclk);

        // table-driven cycles
        for (int i = 0; i < nvec; i++) begin
            sub(tbl[i].din, tbl[i].cm, tbl[i].sy);
            chk($sformatf("v%0d_oe", i), {7'd0, bus.data_oe}, {7'd0, tbl[i].oe});
            chk($sformatf("v%0d_fsel", i), {7'd0, bus.fetch_sel}, {7'd0, tbl[i].fs});
            chk($sformatf("v%0d_io", i), {4'd0, io_out}, {4'd0, tbl[i].io});
            if (tbl[i].oe)
                chk($sformatf("v%0d_dout", i), {4'd0, bus.data_out}, {4'd0, tbl[i].dout});
            if (tbl[i].ra_chk)
                chk($sformatf("v%0d_addr", i), rom_addr, tbl[i].ra);
        end

        // sync at the M1 tick: back to A1, M2 drive abandoned
        sub(4'h5, 1'b0, 1'b0);
        sub(4'hA, 1'b0, 1'b0);
        sub(4'h3, 1'b1, 1'b0);
        chk("rs_m1_oe", {7'd0, bus.data_oe}, 8'h01);
        chk("rs_m1_dout", {4'd0, bus.data_out}, 8'h0D);
        sub(4'hD, 1'b0, 1'b1);
        chk("rs_oe", {7'd0, bus.data_oe}, 8'h00);
        chk("rs_fsel", {7'd0, bus.fetch_sel}, 8'h00);
        oe_seen = 1'b0;
        sub(4'h6, 1'b0, 1'b0);
        chk("rs_a1_addr", rom_addr, 8'hA6);
        sub(4'hB, 1'b0, 1'b0);
        chk("rs_a2_addr", rom_addr, 8'hB6);
        sub(4'h0, 1'b0, 1'b0);
        repeat (4) sub(4'h0, 1'b0, 1'b0);
        // X3 tick without sync -> unsynchronised; bus ignored
        sub(4'h0, 1'b0, 1'b0);
        sub(4'hF, 1'b0, 1'b0);
        sub(4'h3, 1'b1, 1'b0);
        sub(4'h7, 1'b1, 1'b0);
        sub(4'h1, 1'b0, 1'b0);
        chk("unsync_oe_seen", {7'd0, oe_seen}, 8'h00);
        chk("unsync_addr", rom_addr, 8'hB6);

        // reset in the middle of the M2 drive
        sub(4'h0, 1'b0, 1'b1);
        sub(4'h5, 1'b0, 1'b0);
        sub(4'hA, 1'b0, 1'b0);
        sub(4'h3, 1'b1, 1'b0);
        sub(4'hD, 1'b0, 1'b0);
        chk("pr_m2_oe", {7'd0, bus.data_oe}, 8'h01);
        chk("pr_m2_dout", {4'd0, bus.data_out}, 8'h07);
        chk("pr_io_before", {4'd0, io_out}, 8'h09);
        bus.data_in = 4'h7;
        bus.clk2    = 1'b1;
        @(negedge sysclk);
        poc_n = 1'b0;
        @(negedge sysclk);
        chk("pr_oe", {7'd0, bus.data_oe}, 8'h00);
        chk("pr_fsel", {7'd0, bus.fetch_sel}, 8'h00);
        chk("pr_dout", {4'd0, bus.data_out}, 8'h00);
        chk("pr_io", {4'd0, io_out}, 8'h0C);
        chk("pr_addr", rom_addr, 8'h00);
        poc_n    = 1'b1;
        bus.clk2 = 1'b0;
        @(negedge sysclk);
        oe_seen = 1'b0;
        sub(4'h5, 1'b0, 1'b0);
        sub(4'hA, 1'b0, 1'b0);
        sub(4'h3, 1'b1, 1'b0);
        sub(4'hD, 1'b0, 1'b0);
        chk("pr_ignore_oe", {7'd0, oe_seen}, 8'h00);
        chk("pr_ignore_addr", rom_addr, 8'h00);
        sub(4'h0, 1'b0, 1'b1);
        sub(4'h5, 1'b0, 1'b0);
        sub(4'hA, 1'b0, 1'b0);
        sub(4'h3, 1'b1, 1'b0);
        chk("pr_refetch_oe", {7'd0, bus.data_oe}, 8'h01);
        chk("pr_refetch_dout", {4'd0, bus.data_out}, 8'h0D);
        chk("pr_refetch_fsel", {7'd0, bus.fetch_sel}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
